// File: rtl/bcd_multi_counter.sv
// ---------------------------------------------------------------------------
// bcd_multi_counter
//
// Multi-digit BCD event counter for score, timer and cycle-count displays.
// Slow inc/dec strobes are rising-edge detected, the digits ripple within a
// single cycle, and the counter either wraps or saturates at its limits.
//
// Optional feature macro: BCD_CNT_DOWN_EN
//   defined   -> dec edge detector, borrow chain and borrow output are built;
//                an inc and a dec event in the same cycle cancel.
//   undefined -> dec is ignored, borrow is tied to 0, up events never cancel.
//
// Parameters:
//   DIGITS   number of BCD digits (1..8)
//   WRAP     1 = wrap at the count limits, 0 = saturate at the limits
//
// Ports:
//   clk       in   system clock, all state on rising edge
//   reset     in   asynchronous reset, active low
//   clr       in   synchronous clear to zero (highest priority)
//   load      in   synchronous parallel load of load_val
//   load_val  in   BCD load value, nibble 0 least significant, >9 clamps to 9
//   inc       in   count-up strobe, rising-edge detected
//   dec       in   count-down strobe, rising-edge detected
//   val       out  current count in BCD, nibble 0 least significant
//   carry     out  one-cycle pulse: up event at all-9s
//   borrow    out  one-cycle pulse: down event at all-0s
//   zero      out  val is all-0s (combinational)
//   max       out  val is all-9s (combinational)
// ---------------------------------------------------------------------------
module bcd_multi_counter #(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                inc,
  input  logic                dec,
  output logic [4*DIGITS-1:0] val,
  output logic                carry,
  output logic                borrow,
  output logic                zero,
  output logic                max
);

  logic                q1_inc;
  logic                q2_inc;
  logic                up_evt;
  logic                up_act;
  logic [4*DIGITS-1:0] val_q;
  logic [4*DIGITS-1:0] val_d;
  logic [4*DIGITS-1:0] inc_val;
  logic [4*DIGITS-1:0] load_clamped;
  logic                inc_ripple;
  logic                all_nine;
  logic                all_zero;
  logic                carry_q;
  logic                carry_d;

`ifdef BCD_CNT_DOWN_EN
  logic                q1_dec;
  logic                q2_dec;
  logic                dn_evt;
  logic                dn_act;
  logic [4*DIGITS-1:0] dec_val;
  logic                dec_ripple;
  logic                borrow_q;
  logic                borrow_d;
`else
  logic                dec_unused;
`endif

  // Edge-detect flops reset to 1 so a strobe already high when reset is
  // released looks like "no edge" instead of a spurious count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_inc <= 1'b1;
      q2_inc <= 1'b1;
    end else begin
      q1_inc <= inc;
      q2_inc <= q1_inc;
    end
  end

  assign up_evt = q1_inc & ~q2_inc;

`ifdef BCD_CNT_DOWN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q1_dec <= 1'b1;
      q2_dec <= 1'b1;
    end else begin
      q1_dec <= dec;
      q2_dec <= q1_dec;
    end
  end

  assign dn_evt = q1_dec & ~q2_dec;

  // Simultaneous up and down events cancel each other.
  assign up_act = up_evt & ~dn_evt;
  assign dn_act = dn_evt & ~up_evt;
`else
  assign up_act     = up_evt;
  assign dec_unused = dec;
`endif

  // Increment ripple: digits at 9 roll to 0 and pass the carry upward until
  // a digit below 9 absorbs it. At all-9s the result is naturally all-0s,
  // which is exactly the wrap value.
  always_comb begin
    inc_val    = val_q;
    inc_ripple = 1'b1;
    all_nine   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (val_q[4*i +: 4] != 4'd9) begin
        all_nine = 1'b0;
      end
      if (inc_ripple) begin
        if (val_q[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = val_q[4*i +: 4] + 4'd1;
          inc_ripple        = 1'b0;
        end
      end
    end
  end

`ifdef BCD_CNT_DOWN_EN
  // Decrement ripple: digits at 0 roll to 9 and borrow from the next digit.
  // At all-0s the result is all-9s, the wrap value.
  always_comb begin
    dec_val    = val_q;
    dec_ripple = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (dec_ripple) begin
        if (val_q[4*i +: 4] == 4'd0) begin
          dec_val[4*i +: 4] = 4'd9;
        end else begin
          dec_val[4*i +: 4] = val_q[4*i +: 4] - 4'd1;
          dec_ripple        = 1'b0;
        end
      end
    end
  end
`endif

  assign all_zero = (val_q == '0);

  // Out-of-range load nibbles clamp to 9 so val never leaves BCD.
  always_comb begin
    load_clamped = load_val;
    for (int i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_clamped[4*i +: 4] = 4'd9;
      end
    end
  end

  // Priority: clr, then load, then a single surviving event. Events that
  // arrive in a clr or load cycle are simply dropped.
  always_comb begin
    val_d   = val_q;
    carry_d = 1'b0;
`ifdef BCD_CNT_DOWN_EN
    borrow_d = 1'b0;
`endif
    if (clr) begin
      val_d = '0;
    end else if (load) begin
      val_d = load_clamped;
    end else if (up_act) begin
      carry_d = all_nine;
      if (!all_nine || WRAP) begin
        val_d = inc_val;
      end
    end
`ifdef BCD_CNT_DOWN_EN
    else if (dn_act) begin
      borrow_d = all_zero;
      if (!all_zero || WRAP) begin
        val_d = dec_val;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      val_q   <= val_d;
      carry_q <= carry_d;
    end
  end

`ifdef BCD_CNT_DOWN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
    end
  end

  assign borrow = borrow_q;
`else
  assign borrow = 1'b0;
`endif

  assign val   = val_q;
  assign carry = carry_q;
  assign zero  = all_zero;
  assign max   = all_nine;

endmodule

// File: tb/tb_bcd_multi_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_multi_counter
//
// Drives a wrapping (WRAP=1) and a saturating (WRAP=0) 4-digit counter with
// the same stimulus. An integer reference model predicts each result, which
// is queued when stimulus is applied and popped when the output is sampled.
// Down-count expectations follow BCD_CNT_DOWN_EN.
// ---------------------------------------------------------------------------
module tb_bcd_multi_counter;

`ifdef BCD_CNT_DOWN_EN
  localparam bit DOWN_EN = 1'b1;
`else
  localparam bit DOWN_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        clr;
  logic        load;
  logic [15:0] load_val;
  logic        inc;
  logic        dec;

  logic [15:0] val_w;
  logic        carry_w;
  logic        borrow_w;
  logic        zero_w;
  logic        max_w;
  logic [15:0] val_s;
  logic        carry_s;
  logic        borrow_s;
  logic        zero_s;
  logic        max_s;

  bcd_multi_counter #(.DIGITS(4), .WRAP(1'b1)) dut_wrap (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .val(val_w), .carry(carry_w), .borrow(borrow_w),
    .zero(zero_w), .max(max_w)
  );

  bcd_multi_counter #(.DIGITS(4), .WRAP(1'b0)) dut_sat (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .load_val(load_val),
    .inc(inc), .dec(dec), .val(val_s), .carry(carry_s), .borrow(borrow_s),
    .zero(zero_s), .max(max_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum logic [2:0] {OP_IDLE, OP_LOAD, OP_CLR, OP_INC, OP_DEC, OP_BOTH} op_t;

  typedef struct {
    string       tag;
    logic [15:0] vw;
    logic [15:0] vs;
    logic        cw;
    logic        cs;
    logic        bw;
    logic        bs;
  } exp_t;

  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;
  int mw = 0;
  int ms = 0;
  int exp_carries_w = 0;
  int exp_carries_s = 0;
  int obs_carries_w = 0;
  int obs_carries_s = 0;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int t;
    t = n;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int clamp_to_int(input logic [15:0] b);
    int n;
    int d;
    n = 0;
    for (int i = 3; i >= 0; i--) begin
      d = int'(b[4*i +: 4]);
      if (d > 9) d = 9;
      n = n * 10 + d;
    end
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_expect(input string tag, input logic cw, input logic cs,
                             input logic bw, input logic bs);
    exp_t e;
    e.tag = tag;
    e.vw  = to_bcd(mw);
    e.vs  = to_bcd(ms);
    e.cw  = cw;
    e.cs  = cs;
    e.bw  = bw;
    e.bs  = bs;
    exp_carries_w += int'(cw);
    exp_carries_s += int'(cs);
    sb.push_back(e);
  endtask

  // Model one up event on both counters and queue the result.
  task automatic model_up(input string tag);
    logic cw;
    logic cs;
    cw = (mw == 9999);
    cs = (ms == 9999);
    mw = cw ? 0 : mw + 1;
    ms = cs ? ms : ms + 1;
    push_expect(tag, cw, cs, 1'b0, 1'b0);
  endtask

  task automatic model_down(input string tag);
    logic bw;
    logic bs;
    bw = (mw == 0);
    bs = (ms == 0);
    mw = bw ? 9999 : mw - 1;
    ms = bs ? ms : ms - 1;
    push_expect(tag, 1'b0, 1'b0, bw, bs);
  endtask

  // Each op starts just after a rising edge with all strobes low and leaves
  // the outputs ready to sample just after the edge where the result lands.
  task automatic apply_stimulus(input op_t op, input logic [15:0] arg, input string tag);
    case (op)
      OP_LOAD: begin
        load = 1'b1; load_val = arg;
        mw = clamp_to_int(arg); ms = mw;
        push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        load = 1'b0;
      end
      OP_CLR: begin
        clr = 1'b1;
        mw = 0; ms = 0;
        push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        clr = 1'b0;
      end
      OP_INC: begin
        inc = 1'b1;
        tick();
        inc = 1'b0;
        model_up(tag);
        tick();
      end
      OP_DEC: begin
        dec = 1'b1;
        tick();
        dec = 1'b0;
        if (DOWN_EN) model_down(tag);
        else         push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
      end
      OP_BOTH: begin
        inc = 1'b1; dec = 1'b1;
        tick();
        inc = 1'b0; dec = 1'b0;
        if (DOWN_EN) push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        else         model_up(tag);
        tick();
      end
      default: begin
        push_expect(tag, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
      end
    endcase
  endtask

  task automatic check_output();
    exp_t e;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      cmp({e.tag, ".val_w"},    32'(val_w),    32'(e.vw));
      cmp({e.tag, ".val_s"},    32'(val_s),    32'(e.vs));
      cmp({e.tag, ".carry_w"},  32'(carry_w),  32'(e.cw));
      cmp({e.tag, ".carry_s"},  32'(carry_s),  32'(e.cs));
      cmp({e.tag, ".borrow_w"}, 32'(borrow_w), 32'(e.bw));
      cmp({e.tag, ".borrow_s"}, 32'(borrow_s), 32'(e.bs));
      cmp({e.tag, ".zero_w"},   32'(zero_w),   32'(e.vw == 16'h0000));
      cmp({e.tag, ".max_w"},    32'(max_w),    32'(e.vw == 16'h9999));
      cmp({e.tag, ".zero_s"},   32'(zero_s),   32'(e.vs == 16'h0000));
      cmp({e.tag, ".max_s"},    32'(max_s),    32'(e.vs == 16'h9999));
      obs_carries_w += int'(carry_w === 1'b1);
      obs_carries_s += int'(carry_s === 1'b1);
    end
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
    inc = 1'b1; dec = 1'b0;
    #2;
    push_expect("reset_state", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output();

    // Release reset between edges while inc is held high: no count.
    tick(); tick();
    #3 reset = 1'b1;
    tick(); tick(); tick();
    push_expect("inc_held_over_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output();
    inc = 1'b0;
    tick(); tick();

    apply_stimulus(OP_LOAD, 16'h0199, "load_0199");   check_output();
    apply_stimulus(OP_INC,  16'h0000, "ripple_up");   check_output();
    apply_stimulus(OP_LOAD, 16'hA5F3, "load_clamp");  check_output();
    apply_stimulus(OP_LOAD, 16'h9999, "load_9999");   check_output();
    apply_stimulus(OP_INC,  16'h0000, "up_at_limit"); check_output();
    apply_stimulus(OP_IDLE, 16'h0000, "carry_drop");  check_output();

    // clr and load in the same cycle as a valid inc event.
    apply_stimulus(OP_LOAD, 16'h0500, "load_0500");   check_output();
    inc = 1'b1;
    tick();
    clr = 1'b1; load = 1'b1; load_val = 16'h1234;
    mw = 0; ms = 0;
    push_expect("clr_load_inc", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    clr = 1'b0; load = 1'b0; inc = 1'b0;
    check_output();
    apply_stimulus(OP_IDLE, 16'h0000, "after_clr_load"); check_output();

    apply_stimulus(OP_DEC,  16'h0000, "down_at_limit");  check_output();
    apply_stimulus(OP_IDLE, 16'h0000, "borrow_drop");    check_output();
    apply_stimulus(OP_BOTH, 16'h0000, "inc_dec_same");   check_output();
    apply_stimulus(OP_DEC,  16'h0000, "down_again");     check_output();

    // Async reset between edges with an event pending.
    apply_stimulus(OP_LOAD, 16'h0042, "load_0042");      check_output();
    inc = 1'b1;
    tick();
    #2 reset = 1'b0;
    #1;
    mw = 0; ms = 0;
    push_expect("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check_output();
    inc = 1'b0;
    #2 reset = 1'b1;
    tick(); tick();
    apply_stimulus(OP_IDLE, 16'h0000, "after_async_reset"); check_output();

    // Throughput from zero.
    apply_stimulus(OP_CLR, 16'h0000, "clr_tp"); check_output();
    exp_carries_w = 0; exp_carries_s = 0; obs_carries_w = 0; obs_carries_s = 0;
    for (int i = 0; i < 250; i++) begin
      apply_stimulus(OP_INC, 16'h0000, "tp_up");
      check_output();
    end
    cmp("tp250_final_val", 32'(val_w), 32'h0000_0250);
    cmp("tp250_carries_w", 32'(obs_carries_w), 32'(exp_carries_w));
    cmp("tp250_carries_s", 32'(obs_carries_s), 32'(exp_carries_s));

    // Throughput across the limit.
    apply_stimulus(OP_LOAD, 16'h9990, "load_9990"); check_output();
    exp_carries_w = 0; exp_carries_s = 0; obs_carries_w = 0; obs_carries_s = 0;
    for (int i = 0; i < 15; i++) begin
      apply_stimulus(OP_INC, 16'h0000, "tp_wrap");
      check_output();
    end
    cmp("tp15_final_val_w", 32'(val_w), 32'h0000_0005);
    cmp("tp15_carries_w",   32'(obs_carries_w), 32'd1);
    cmp("tp15_carries_s",   32'(obs_carries_s), 32'(exp_carries_s));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
